// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute/memory stage: ALU op codes, FSM states,
// and the write-back control bundle carried alongside each result.
package ex_mem_stage_pkg;

    localparam int unsigned ALU_OP_W  = 3;
    localparam int unsigned LAT_CNT_W = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_PASS_A = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_NEG    = 3'b010,
        ALU_ADD    = 3'b100,
        ALU_PASS_B = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_e;

    typedef struct packed {
        logic memtoreg;
        logic jump;
        logic regwrite;
        logic jumpm;
    } wb_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_alu_core.sv
// Combinational ALU; codes outside the defined set produce zero.
module alu_core
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [DATA_W-1:0]   result_c
);

    alu_op_e op_e;

    assign op_e = alu_op_e'(op);

    always_comb begin
        result_c = '0;
        case (op_e)
            ALU_ADD:    result_c = a + b;
            ALU_SUB:    result_c = a - b;
            ALU_NEG:    result_c = '0 - a;
            ALU_PASS_B: result_c = b;
            ALU_PASS_A: result_c = a;
            default:    result_c = '0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Registered execute/memory stage: ALU, word-addressed data memory with
// configurable read latency, valid/ready handshake toward write-back.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   pc,
    input  logic [DATA_W-1:0]   rs1,
    input  logic [DATA_W-1:0]   rs2,
    input  logic [DATA_W-1:0]   imm,
    input  logic                alu_src,
    input  logic                pc_control,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                memtoreg_in,
    input  logic                jump_in,
    input  logic                regwrite_in,
    input  logic                jumpm_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   alu_result,
    output logic                zero,
    output logic                neg,
    output logic [DATA_W-1:0]   read_data,
    output logic                memtoreg_out,
    output logic                jump_out,
    output logic                regwrite_out,
    output logic                jumpm_out
);

    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);
    localparam bit SLOW_LOAD_EN = (MEM_LAT > 1);

    state_e                 state;
    state_e                 state_next;
    logic                   accept_c;
    logic                   slow_load_c;
    logic                   load_done_c;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic [DATA_W-1:0]      load_buf;
    logic [ADDR_W-1:0]      idx_c;
    logic [DATA_W-1:0]      op_a_c;
    logic [DATA_W-1:0]      op_b_c;
    logic [DATA_W-1:0]      alu_res_c;
    wb_ctrl_t               wb_ctrl_c;
    wb_ctrl_t               wb_ctrl_q;
    logic [DATA_W-1:0]      mem [MEM_DEPTH];
    logic                   unused_addr_bits;

    // Address wraps: only the low index bits select a word.
    assign idx_c            = rs1[ADDR_W-1:0];
    assign unused_addr_bits = ^rs1[DATA_W-1:ADDR_W];

    assign op_a_c      = pc_control ? rs1 : pc;
    assign op_b_c      = alu_src ? rs2 : imm;
    assign slow_load_c = mem_read & SLOW_LOAD_EN;

    assign wb_ctrl_c = '{memtoreg: memtoreg_in, jump: jump_in,
                         regwrite: regwrite_in, jumpm: jumpm_in};

    assign memtoreg_out = wb_ctrl_q.memtoreg;
    assign jump_out     = wb_ctrl_q.jump;
    assign regwrite_out = wb_ctrl_q.regwrite;
    assign jumpm_out    = wb_ctrl_q.jumpm;

    alu_core #(
        .DATA_W   (DATA_W)
    ) u_alu (
        .a        (op_a_c),
        .b        (op_b_c),
        .op       (alu_op),
        .result_c (alu_res_c)
    );

    // State register; out_valid mirrors the VALID state one-for-one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next == VALID);
        end
    end

    // Next-state and handshake decode; VALID passes out_ready straight through
    // so back-to-back single-cycle traffic sees no bubble.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        load_done_c = 1'b0;
        accept_c    = 1'b0;

        case (state)
            IDLE:    in_ready    = 1'b1;
            WAIT:    load_done_c = (lat_cnt == '0);
            VALID:   in_ready    = out_ready;
            default: in_ready    = 1'b0;
        endcase

        accept_c = in_valid & in_ready;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_next = slow_load_c ? WAIT : VALID;
                end
            end
            WAIT: begin
                if (load_done_c) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    if (accept_c) begin
                        state_next = slow_load_c ? WAIT : VALID;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result, flag and control registers; the old word is snapshotted on accept
    // so a same-cycle store cannot corrupt a slow load.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result <= '0;
            zero       <= 1'b0;
            neg        <= 1'b0;
            read_data  <= '0;
            wb_ctrl_q  <= '0;
            load_buf   <= '0;
            lat_cnt    <= '0;
        end else if (accept_c) begin
            alu_result <= alu_res_c;
            zero       <= (alu_res_c == '0);
            neg        <= alu_res_c[DATA_W-1];
            wb_ctrl_q  <= wb_ctrl_c;
            read_data  <= (mem_read && !SLOW_LOAD_EN) ? mem[idx_c] : '0;
            load_buf   <= mem[idx_c];
            lat_cnt    <= LAT_INIT;
        end else if (state == WAIT) begin
            if (load_done_c) begin
                read_data <= load_buf;
            end else begin
                lat_cnt <= lat_cnt - LAT_CNT_W'(1);
            end
        end
    end

    // Data memory: contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && accept_c && mem_write) begin
            mem[idx_c] <= rs2;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized bench for ex_mem_stage against a cycle-count and
// queue based reference model.
module tb_ex_mem_stage;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned MEM_LAT   = 2;

    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic        neg;
        logic [31:0] rd;
        logic [3:0]  ctl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc, rs1, rs2, imm;
    logic        alu_src, pc_control;
    logic [2:0]  alu_op;
    logic        mem_read, mem_write;
    logic        memtoreg_in, jump_in, regwrite_in, jumpm_in;
    logic        out_valid, out_ready;
    logic [31:0] alu_result, read_data;
    logic        zero, neg;
    logic        memtoreg_out, jump_out, regwrite_out, jumpm_out;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          pend = 0;
    int          wait_left = 0;
    exp_t        q[$];
    logic [31:0] ref_mem [MEM_DEPTH];

    always #5 clk = ~clk;

    ex_mem_stage #(
        .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
        .alu_src(alu_src), .pc_control(pc_control), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write),
        .memtoreg_in(memtoreg_in), .jump_in(jump_in),
        .regwrite_in(regwrite_in), .jumpm_in(jumpm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero), .neg(neg), .read_data(read_data),
        .memtoreg_out(memtoreg_out), .jump_out(jump_out),
        .regwrite_out(regwrite_out), .jumpm_out(jumpm_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'b100:  return a + b;
            3'b001:  return a - b;
            3'b010:  return 32'd0 - a;
            3'b111:  return b;
            3'b000:  return a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic pctl,
                         input logic asrc, input logic [31:0] p, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im,
                         input logic mr, input logic mw);
        logic [3:0] c;
        c = 4'($urandom);
        in_valid = v; alu_op = op; pc_control = pctl; alu_src = asrc;
        pc = p; rs1 = r1; rs2 = r2; imm = im; mem_read = mr; mem_write = mw;
        {memtoreg_in, jump_in, regwrite_in, jumpm_in} = c;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // One clock: check handshake and any visible result against the model,
    // record an accept, then advance the model across the edge.
    task automatic tick();
        logic exp_rdy, exp_ov, acc, xfer;
        logic [31:0] a, b;
        exp_t e;
        #1;
        exp_ov  = (pend > 0) && (wait_left == 0);
        exp_rdy = (wait_left > 0) ? 1'b0 : ((pend == 0) ? 1'b1 : out_ready);
        acc  = 1'b0;
        xfer = 1'b0;
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov && q.size() > 0) begin
                e = q[0];
                chk("alu_result", alu_result, e.alu);
                chk("zero", 32'(zero), 32'(e.zero));
                chk("neg", 32'(neg), 32'(e.neg));
                chk("read_data", read_data, e.rd);
                chk("wb_ctrl", 32'({memtoreg_out, jump_out, regwrite_out, jumpm_out}),
                    32'(e.ctl));
            end
            xfer = exp_ov && out_ready;
            acc  = in_valid && exp_rdy;
            if (xfer && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                a     = pc_control ? rs1 : pc;
                b     = alu_src ? rs2 : imm;
                e.alu = ref_alu(alu_op, a, b);
                e.zero = (e.alu == 32'd0);
                e.neg  = e.alu[31];
                e.rd   = mem_read ? ref_mem[rs1[7:0]] : 32'd0;
                e.ctl  = {memtoreg_in, jump_in, regwrite_in, jumpm_in};
                if (mem_write) ref_mem[rs1[7:0]] = rs2;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            pend = 0;
            wait_left = 0;
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_alu_result", alu_result, 32'd0);
            chk("rst_read_data", read_data, 32'd0);
            chk("rst_flags", 32'({zero, neg}), 32'd0);
            chk("rst_ctrl", 32'({memtoreg_out, jump_out, regwrite_out, jumpm_out}), 32'd0);
        end else begin
            if (wait_left > 0) wait_left--;
            if (xfer) pend--;
            if (acc) begin
                pend++;
                if (mem_read && MEM_LAT > 1) wait_left = MEM_LAT;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Give the low 16 words known contents.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'b100, 1'b1, 1'b1, 32'd0, 32'(i), $urandom, 32'd0, 1'b0, 1'b1);
            tick();
        end
        idle();
        tick();

        drive(1'b1, 3'b100, 1'b1, 1'b1, $urandom, 32'd5, 32'd7, $urandom, 1'b0, 1'b0);
        tick();
        idle();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", alu_result, 32'd12);
        chk("add_flags", 32'({zero, neg}), 32'd0);
        tick();

        drive(1'b1, 3'b001, 1'b1, 1'b1, $urandom, 32'd9, 32'd9, $urandom, 1'b0, 1'b0);
        tick();
        idle();
        chk("sub_result", alu_result, 32'd0);
        chk("sub_zero", 32'(zero), 32'd1);
        tick();

        drive(1'b1, 3'b010, 1'b1, 1'b0, $urandom, 32'd1, $urandom, $urandom, 1'b0, 1'b0);
        tick();
        idle();
        chk("neg_result", alu_result, 32'hFFFF_FFFF);
        chk("neg_flag", 32'(neg), 32'd1);
        tick();

        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h40, $urandom, $urandom, $urandom, 1'b0, 1'b0);
        tick();
        idle();
        chk("pass_a_result", alu_result, 32'h40);
        tick();

        // Store at 0x104 aliases word 4; the load back takes MEM_LAT cycles.
        drive(1'b1, 3'b100, 1'b1, 1'b1, 32'd0, 32'h104, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 3'b100, 1'b1, 1'b0, 32'd0, 32'h004, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        idle();
        chk("wrap_busy0", 32'(in_ready), 32'd0);
        tick();
        chk("wrap_busy1", 32'(in_ready), 32'd0);
        tick();
        chk("wrap_valid", 32'(out_valid), 32'd1);
        chk("wrap_data", read_data, 32'hDEAD_BEEF);
        tick();

        // Reset while a load is waiting on memory.
        drive(1'b1, 3'b100, 1'b1, 1'b0, 32'd0, 32'd2, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Back-pressure: first result must hold while out_ready is low.
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 1'b1, 1'b1, 32'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b100, 1'b1, 1'b1, 32'd0, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_stall", 32'(in_ready), 32'd0);
            chk("bp_hold", alu_result, 32'd3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_second", alu_result, 32'd30);
        drive(1'b1, 3'b100, 1'b1, 1'b1, 32'd0, 32'd100, 32'd200, 32'd0, 1'b0, 1'b0);
        tick();
        idle();
        chk("bp_third", alu_result, 32'd300);
        tick();

        // Read-before-write on a combined load/store.
        drive(1'b1, 3'b100, 1'b1, 1'b1, 32'd0, 32'd3, 32'h11, 32'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 3'b100, 1'b1, 1'b1, 32'd0, 32'd3, 32'h22, 32'd0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        tick();
        chk("rbw_old", read_data, 32'h11);
        tick();
        drive(1'b1, 3'b100, 1'b1, 1'b1, 32'd0, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("rbw_new", read_data, 32'h22);
        tick();

        // Random traffic confined to the initialised words, upper address bits random.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r1, r2;
            r1 = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            r2 = ($urandom_range(0, 7) == 0) ? r1 : $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 9) < 7), 3'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, r1, r2, $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            tick();
        end

        out_ready = 1'b1;
        idle();
        for (int i = 0; i < 8; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
